// File: rtl/fifo_axis_egress.sv
// fifo_axis_egress: drains a first-word-fall-through FIFO into an AXI4-Stream
// master through a registered two-entry buffer (OUT drives the stream, SKID
// catches the single word popped after tready falls), and frames the stream
// into BURST_LEN-beat packets.
// Optional feature macro: FIFO_AXIS_EGRESS_TLAST_EN. When defined, tlast
// framing, the beat index and the packet counter are built; when undefined,
// m_axis_tlast_o, beat_idx_o and pkt_cnt_o are tied to 0 and the buffer
// entries carry no last bit.
module fifo_axis_egress #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int CntWidth   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tlast_o,
  output logic [CntWidth-1:0]   beat_idx_o,
  output logic [15:0]           pkt_cnt_o
);

  logic                  pop;
  logic                  hs;
  logic                  out_from_skid;
  logic                  out_from_fifo;
  logic                  skid_load;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] out_data_d;
  logic                  out_valid_q;
  logic                  out_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [DATA_WIDTH-1:0] skid_data_d;
  logic                  skid_valid_q;
  logic                  skid_valid_d;

  // A pop only needs SKID to have room; tready never feeds this path, so the
  // FIFO pop timing is independent of the downstream ready.
  assign pop = enable_i & ~fifo_empty_i & ~skid_valid_q;
  assign hs  = out_valid_q & m_axis_tready_i;

  // Buffer moves: SKID refills OUT on a handshake; otherwise the popped word
  // lands in OUT when OUT is free (or being consumed), else in SKID.
  // A handshake with SKID full implies no pop, so the two OUT loads are exclusive.
  assign out_from_skid = hs & skid_valid_q;
  assign out_from_fifo = pop & (~out_valid_q | hs);
  assign skid_load     = pop & out_valid_q & ~hs;

  // Next state for the data/valid fields of OUT and SKID.
  always_comb begin
    out_data_d   = out_data_q;
    skid_data_d  = skid_data_q;
    out_valid_d  = out_from_skid | out_from_fifo | (out_valid_q & ~hs);
    skid_valid_d = skid_load | (skid_valid_q & ~hs);
    if (out_from_skid) begin
      out_data_d = skid_data_q;
    end else if (out_from_fifo) begin
      out_data_d = fifo_data_i;
    end
    if (skid_load) begin
      skid_data_d = fifo_data_i;
    end
  end

  // Buffer registers; reset discards anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign fifo_pop_o      = pop;
  assign m_axis_tdata_o  = out_data_q;
  assign m_axis_tvalid_o = out_valid_q;

`ifdef FIFO_AXIS_EGRESS_TLAST_EN
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(BURST_LEN - 1);

  logic                pop_last;
  logic                out_last_q;
  logic                out_last_d;
  logic                skid_last_q;
  logic                skid_last_d;
  logic [CntWidth-1:0] beat_idx_q;
  logic [CntWidth-1:0] beat_idx_d;
  logic [15:0]         pkt_cnt_q;
  logic [15:0]         pkt_cnt_d;

  // The word being popped closes the packet when the index sits on the last slot.
  assign pop_last = (beat_idx_q == LastIdx);

  // Last bits follow their data words; beat index advances per pop and holds
  // while enable_i is low; packets are counted when the last beat is accepted.
  always_comb begin
    out_last_d  = out_last_q;
    skid_last_d = skid_last_q;
    beat_idx_d  = beat_idx_q;
    pkt_cnt_d   = pkt_cnt_q;
    if (out_from_skid) begin
      out_last_d = skid_last_q;
    end else if (out_from_fifo) begin
      out_last_d = pop_last;
    end
    if (skid_load) begin
      skid_last_d = pop_last;
    end
    if (pop) begin
      beat_idx_d = pop_last ? '0 : beat_idx_q + CntWidth'(1);
    end
    if (hs & out_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Framing registers; reset restarts the packet at beat 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_last_q  <= 1'b0;
      skid_last_q <= 1'b0;
      beat_idx_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      out_last_q  <= out_last_d;
      skid_last_q <= skid_last_d;
      beat_idx_q  <= beat_idx_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign m_axis_tlast_o = out_last_q;
  assign beat_idx_o     = beat_idx_q;
  assign pkt_cnt_o      = pkt_cnt_q;
`else
  assign m_axis_tlast_o = 1'b0;
  assign beat_idx_o     = '0;
  assign pkt_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_fifo_axis_egress.sv
// Bench for fifo_axis_egress (BURST_LEN = 4): a cycle table for the streaming
// case, hand-written reset/backpressure/alternating/pause sequences, and a
// randomized phase, all watched by a queue-based reference model.
module tb_fifo_axis_egress;
  localparam int BL = 4;
`ifdef FIFO_AXIS_EGRESS_TLAST_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tready = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pop;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [1:0]  beat_idx;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_axis_egress #(.DATA_WIDTH(32), .BURST_LEN(BL)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data), .fifo_pop_o(fifo_pop),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .m_axis_tlast_o(tlast), .beat_idx_o(beat_idx), .pkt_cnt_o(pkt_cnt)
  );

  // First-word-fall-through FIFO model feeding the DUT.
  logic [31:0] fmem [0:4095];
  logic [11:0] wr_ptr = 12'd0;
  logic [11:0] rd_ptr = 12'd0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = fmem[rd_ptr];
  always @(posedge clk) if (fifo_pop && !fifo_empty) rd_ptr <= rd_ptr + 12'd1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_ptr] = w;
    wr_ptr = wr_ptr + 12'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of beats in flight, pop count, packet count.
  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  beat_t       exp_q[$];
  int unsigned m_pops = 0;
  int unsigned m_pkts = 0;
  bit          model_ok = 1'b0;
  logic [31:0] rx_data [0:4095];
  logic        rx_last [0:4095];
  int unsigned rx_cnt = 0;

  initial forever begin : monitor
    bit    exp_pop;
    beat_t b;
    @(negedge clk);
    if (model_ok) begin
      exp_pop = enable && !fifo_empty && (exp_q.size() < 2);
      check("pop", 32'(fifo_pop), 32'(exp_pop));
      check("tvalid", 32'(tvalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("tdata", tdata, exp_q[0].data);
        check("tlast", 32'(tlast), 32'(exp_q[0].last));
      end
      check("beat_idx", 32'(beat_idx), TLAST_ON ? 32'(m_pops % BL) : 32'd0);
      check("pkt_cnt", 32'(pkt_cnt), 32'(m_pkts % 65536));
    end
    if (rst) begin
      exp_q.delete();
      m_pops   = 0;
      m_pkts   = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (tvalid && tready) begin
        rx_data[12'(rx_cnt)] = tdata;
        rx_last[12'(rx_cnt)] = tlast;
        $display("beat %0d data=0x%08h last=%0b pkt=%0d", rx_cnt, tdata, tlast, pkt_cnt);
        rx_cnt++;
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          if (b.last) m_pkts++;
        end
      end
      if (fifo_pop) begin
        b.data = fifo_data;
        b.last = TLAST_ON && ((m_pops % BL) == BL - 1);
        exp_q.push_back(b);
        m_pops++;
      end
    end
  end

  task automatic do_reset();
    step(); rst = 1'b1; enable = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_beat_idx", 32'(beat_idx), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    enable = 1'b1; tready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (fifo_empty && !tvalid) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic wait_rx(input int unsigned base, input int unsigned n, input bit toggle);
    int cyc = 0;
    while ((rx_cnt - base) < n && cyc < 400) begin
      step();
      enable = 1'b1;
      tready = toggle ? ~tready : 1'b1;
      cyc++;
    end
    check("rx_count", rx_cnt - base, n);
  endtask

  task automatic check_rx(input int unsigned base, input int n, input logic [31:0] first, input string name);
    for (int i = 0; i < n; i++) check(name, rx_data[12'(base + 32'(i))], first + 32'(i));
  endtask

  typedef struct {
    logic        en, rdy;
    logic        pop, valid;
    logic [31:0] data;
    logic        last;
    logic [1:0]  idx;
    logic [15:0] pkt;
  } vec_t;

  // Streaming: 8 preloaded words, tready high; values are for the framed build.
  task automatic test_stream();
    vec_t tbl [10];
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 2'd0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 2'd1, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 2'd2, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h12, 1'b0, 2'd3, 16'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 1'b1, 2'd0, 16'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 2'd1, 16'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h15, 1'b0, 2'd2, 16'd1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h16, 1'b0, 2'd3, 16'd1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h17, 1'b1, 2'd0, 16'd1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 16'd2};
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    for (int k = 0; k < 10; k++) begin
      step();
      enable = tbl[k].en; tready = tbl[k].rdy;
      @(negedge clk);
      check("tbl_pop", 32'(fifo_pop), 32'(tbl[k].pop));
      check("tbl_tvalid", 32'(tvalid), 32'(tbl[k].valid));
      if (tbl[k].valid) begin
        check("tbl_tdata", tdata, tbl[k].data);
        check("tbl_tlast", 32'(tlast), 32'(TLAST_ON & tbl[k].last));
      end
      check("tbl_beat_idx", 32'(beat_idx), TLAST_ON ? 32'(tbl[k].idx) : 32'd0);
      check("tbl_pkt_cnt", 32'(pkt_cnt), TLAST_ON ? 32'(tbl[k].pkt) : 32'd0);
    end
  endtask

  // Reset pulsed with a beat buffered; the next beat out is the next FIFO word.
  task automatic test_reset_mid();
    drain();
    do_reset();
    push(32'h300); push(32'h301); push(32'h302);
    step(); enable = 1'b1; tready = 1'b1;
    step(); rst = 1'b1; enable = 1'b0;
    step(); rst = 1'b0;
    @(negedge clk);
    check("rmid_tvalid", 32'(tvalid), 32'd0);
    check("rmid_tdata", tdata, 32'd0);
    check("rmid_tlast", 32'(tlast), 32'd0);
    check("rmid_beat_idx", 32'(beat_idx), 32'd0);
    check("rmid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    step(); enable = 1'b1;
    @(negedge clk);
    check("rmid_pop", 32'(fifo_pop), 32'd1);
    check("rmid_head", fifo_data, 32'h301);
    step();
    @(negedge clk);
    check("rmid_next_tvalid", 32'(tvalid), 32'd1);
    check("rmid_next_tdata", tdata, 32'h301);
    check("rmid_next_idx", 32'(beat_idx), TLAST_ON ? 32'd1 : 32'd0);
  endtask

  // tready low for 5 cycles mid-stream: one extra pop, tdata held, order kept.
  task automatic test_backpressure();
    int unsigned base;
    int          pops = 0;
    logic [31:0] held = 32'd0;
    drain();
    do_reset();
    for (int i = 0; i < 20; i++) push(32'h100 + 32'(i));
    base = rx_cnt;
    step(); enable = 1'b1; tready = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      step(); tready = 1'b0;
      @(negedge clk);
      if (i == 0) held = tdata;
      else check("bp_hold", tdata, held);
      check("bp_tvalid", 32'(tvalid), 32'd1);
      pops += int'(fifo_pop);
    end
    check("bp_pops", 32'(pops), 32'd1);
    wait_rx(base, 20, 1'b0);
    check_rx(base, 20, 32'h100, "bp_order");
  endtask

  // tready toggling every cycle: all 20 words arrive in order.
  task automatic test_alternate();
    int unsigned base;
    drain();
    do_reset();
    for (int i = 0; i < 20; i++) push(32'h400 + 32'(i));
    base = rx_cnt;
    tready = 1'b0;
    wait_rx(base, 20, 1'b1);
    check_rx(base, 20, 32'h400, "alt_order");
  endtask

  // enable low after 2 pops of a 4-beat packet, for 6 cycles; tlast stays on beat 4.
  task automatic test_pause();
    int unsigned base;
    drain();
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
    base = rx_cnt;
    step(); enable = 1'b1; tready = 1'b1;
    step();
    step(); enable = 1'b0;
    repeat (5) step();
    @(negedge clk);
    check("pause_tvalid", 32'(tvalid), 32'd0);
    check("pause_pop", 32'(fifo_pop), 32'd0);
    check("pause_beat_idx", 32'(beat_idx), TLAST_ON ? 32'd2 : 32'd0);
    wait_rx(base, 8, 1'b0);
    check_rx(base, 8, 32'h200, "pause_order");
    for (int i = 0; i < 8; i++)
      check("pause_tlast", 32'(rx_last[12'(base + 32'(i))]), 32'(TLAST_ON && (i % 4 == 3)));
  endtask

  // Random pushes, enable and tready; the monitor model checks every cycle.
  task automatic test_random();
    drain();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step();
      if ($urandom_range(0, 1) == 1 && (wr_ptr - rd_ptr) < 12'd3000) push($urandom);
      enable = ($urandom_range(0, 7) != 0);
      tready = ($urandom_range(0, 3) != 0);
    end
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_stream();
    test_reset_mid();
    test_backpressure();
    test_alternate();
    test_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
